// File: rtl/parking_slot_allocator.sv
// Registered parking-bay allocator: occupancy tracking, auto/manual entry grants, exits, held bay strobe.
// Optional feature macro ROUND_ROBIN_EN: auto search starts after the last granted bay instead of bay 0.
module parking_slot_allocator #(
  parameter int NUM_SLOTS = 4,
  parameter int GATE_HOLD = 1,
  localparam int SW = $clog2(NUM_SLOTS),
  localparam int CW = $clog2(NUM_SLOTS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 entry_req,
  input  logic                 entry_manual,
  input  logic [SW-1:0]        entry_slot,
  input  logic                 exit_req,
  input  logic [SW-1:0]        exit_slot,
  output logic                 grant,
  output logic [SW-1:0]        grant_slot,
  output logic [NUM_SLOTS-1:0] slot_strobe,
  output logic                 reject,
  output logic                 exit_err,
  output logic                 busy,
  output logic [NUM_SLOTS-1:0] occupied,
  output logic [CW-1:0]        free_cnt,
  output logic                 full,
  output logic                 empty
);

  localparam int HW = (GATE_HOLD > 1) ? $clog2(GATE_HOLD) : 1;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t               state_r, state_s;
  logic [HW-1:0]        hold_r, hold_s;
  logic [NUM_SLOTS-1:0] occupied_r, occ_s, strobe_r, strobe_s;
  logic [CW-1:0]        free_cnt_r, free_s;
  logic [SW-1:0]        grant_slot_r, gslot_s, ptr_r, ptr_s, auto_idx_s, tgt_s;
  logic                 grant_r, grant_s, reject_r, reject_s, exit_err_r, exit_err_s;
  logic                 busy_r, full_r, empty_r;
  logic                 found_s, take_s, exit_ok_s;
  logic [SW:0]          idx_s;

  // Next-state logic: free-bay search, hold timing, entry and exit handling
  always_comb begin
    state_s    = state_r;
    hold_s     = hold_r;
    strobe_s   = strobe_r;
    occ_s      = occupied_r;
    gslot_s    = grant_slot_r;
    ptr_s      = ptr_r;
    grant_s    = 1'b0;
    reject_s   = 1'b0;
    exit_err_s = 1'b0;
    exit_ok_s  = 1'b0;
    found_s    = 1'b0;
    take_s     = 1'b0;
    auto_idx_s = '0;
    tgt_s      = '0;
    idx_s      = '0;

    // Search from the pointer, wrapping; the pointer stays 0 without round robin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      idx_s = {1'b0, ptr_r} + (SW+1)'(i);
      if (idx_s >= (SW+1)'(NUM_SLOTS)) begin
        idx_s = idx_s - (SW+1)'(NUM_SLOTS);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && !occupied_r[idx_s[SW-1:0]]) begin
        found_s    = 1'b1;
        auto_idx_s = idx_s[SW-1:0];
      end else begin
        found_s = found_s;
      end
    end

    case (state_r)
      IDLE: strobe_s = '0;
      HOLD: begin
        hold_s = hold_r - HW'(1);
        if (hold_r == HW'(1)) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s  = IDLE;
        strobe_s = '0;
        hold_s   = '0;
      end
    endcase

    // Entry decisions look at pre-exit occupancy, so a bay freed now is not reused this cycle
    if (en && entry_req && (state_r == IDLE)) begin
      if (entry_manual) begin
        tgt_s  = entry_slot;
        take_s = ({1'b0, entry_slot} < (SW+1)'(NUM_SLOTS)) && !occupied_r[entry_slot];
      end else begin
        tgt_s  = auto_idx_s;
        take_s = found_s;
      end
      if (take_s) begin
        grant_s       = 1'b1;
        gslot_s       = tgt_s;
        occ_s[tgt_s]  = 1'b1;
        strobe_s      = NUM_SLOTS'(1) << tgt_s;
        hold_s        = HW'(GATE_HOLD - 1);
        state_s       = (GATE_HOLD > 1) ? HOLD : IDLE;
`ifdef ROUND_ROBIN_EN
        if ({1'b0, tgt_s} == (SW+1)'(NUM_SLOTS - 1)) begin
          ptr_s = '0;
        end else begin
          ptr_s = tgt_s + SW'(1);
        end
`else
        ptr_s = '0;
`endif
      end else begin
        reject_s = 1'b1;
      end
    end else begin
      take_s = 1'b0;
    end

    if (en && exit_req) begin
      if (({1'b0, exit_slot} < (SW+1)'(NUM_SLOTS)) && occupied_r[exit_slot]) begin
        exit_ok_s        = 1'b1;
        occ_s[exit_slot] = 1'b0;
      end else begin
        exit_err_s = 1'b1;
      end
    end else begin
      exit_ok_s = 1'b0;
    end

    free_s = free_cnt_r - CW'(grant_s) + CW'(exit_ok_s);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      hold_r       <= '0;
      occupied_r   <= '0;
      strobe_r     <= '0;
      free_cnt_r   <= CW'(NUM_SLOTS);
      grant_slot_r <= '0;
      ptr_r        <= '0;
      grant_r      <= 1'b0;
      reject_r     <= 1'b0;
      exit_err_r   <= 1'b0;
      busy_r       <= 1'b0;
      full_r       <= 1'b0;
      empty_r      <= 1'b1;
    end else begin
      state_r      <= state_s;
      hold_r       <= hold_s;
      occupied_r   <= occ_s;
      strobe_r     <= strobe_s;
      free_cnt_r   <= free_s;
      grant_slot_r <= gslot_s;
      ptr_r        <= ptr_s;
      grant_r      <= grant_s;
      reject_r     <= reject_s;
      exit_err_r   <= exit_err_s;
      busy_r       <= (state_s == HOLD);
      full_r       <= (free_s == CW'(0));
      empty_r      <= (free_s == CW'(NUM_SLOTS));
    end
  end

  assign grant       = grant_r;
  assign grant_slot  = grant_slot_r;
  assign slot_strobe = strobe_r;
  assign reject      = reject_r;
  assign exit_err    = exit_err_r;
  assign busy        = busy_r;
  assign occupied    = occupied_r;
  assign free_cnt    = free_cnt_r;
  assign full        = full_r;
  assign empty       = empty_r;

endmodule
